// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Multi-channel push-button debouncer for the stopwatch front panel. Each
// channel takes an already-synchronised button level. It accepts a change only
// after STABLE_CNT consecutive identical samples. It then produces a clean
// level and one-cycle press/release strobes.
//
// Parameters
//   N_BTN       number of independent button channels
//   CNT_W       width of each per-channel stability counter
//   STABLE_CNT  consecutive identical samples needed to accept a change
//               (legal range 2 .. 2**CNT_W-1)
//
// Ports
//   s_clk        in   system clock, all logic on the rising edge
//   s_rst        in   asynchronous active-low reset
//   btn_sync     in   [N_BTN] synchronised raw levels, 1 = pressed
//   btn_level    out  [N_BTN] debounced level, registered
//   btn_press    out  [N_BTN] one-cycle strobe on accepted 0->1, registered
//   btn_release  out  [N_BTN] one-cycle strobe on accepted 1->0, registered
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int N_BTN      = 4,
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic             s_clk,
  input  logic             s_rst,
  input  logic [N_BTN-1:0] btn_sync,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  typedef enum logic [1:0] {
    LO      = 2'd0,  // stable released
    WAIT_HI = 2'd1,  // candidate press, counting high samples
    HI      = 2'd2,  // stable pressed
    WAIT_LO = 2'd3   // candidate release, counting low samples
  } state_t;

  // The first sample of a new value is taken on the LO->WAIT_HI
  // (or HI->WAIT_LO) transition and loads the counter with 1. The counter
  // therefore holds "samples seen so far". The sample that finds
  // cnt == STABLE_CNT-1 is the STABLE_CNT-th one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
        state_q   <= LO;
        cnt_q     <= CNT_ZERO;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        // Strobes are single-cycle. They are only raised on the accepting edge.
        press_q   <= 1'b0;
        release_q <= 1'b0;

        case (state_q)
          LO: begin
            if (btn_sync[gi]) begin
              state_q <= WAIT_HI;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= CNT_ZERO;
            end
          end

          WAIT_HI: begin
            if (!btn_sync[gi]) begin
              // Bounce: drop the candidate silently.
              state_q <= LO;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HI;
              cnt_q   <= CNT_ZERO;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              // Compare precedes increment, so the counter never wraps.
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end

          HI: begin
            if (!btn_sync[gi]) begin
              state_q <= WAIT_LO;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= CNT_ZERO;
            end
          end

          WAIT_LO: begin
            if (btn_sync[gi]) begin
              state_q <= HI;
              cnt_q   <= CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= LO;
              cnt_q     <= CNT_ZERO;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q     <= cnt_q + CNT_ONE;
            end
          end

          default: begin
            state_q <= LO;
            cnt_q   <= CNT_ZERO;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed testbench for btn_debounce with STABLE_CNT=4 and N_BTN=4.
// Inputs are driven 1 ns after the rising edge. Outputs are observed at the
// same point, so each observation reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int N_BTN      = 4;
  localparam int CNT_W      = 20;
  localparam int STABLE_CNT = 4;

  logic             s_clk = 1'b0;
  logic             s_rst = 1'b0;
  logic [N_BTN-1:0] btn_sync = '0;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  int n_vec = 0;
  int n_err = 0;

  btn_debounce #(
    .N_BTN      (N_BTN),
    .CNT_W      (CNT_W),
    .STABLE_CNT (STABLE_CNT)
  ) dut (
    .s_clk       (s_clk),
    .s_rst       (s_rst),
    .btn_sync    (btn_sync),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 s_clk = ~s_clk;

  // Advance past one rising edge and settle 1 ns.
  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] e_lvl, e_pr;
    btn_sync = 4'hF;
    s_rst    = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_hold: level=%b press=%b release=%b, expected 0000 0000 0000",
               btn_level, btn_press, btn_release);
    end
    s_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      e_pr  = (k == 3) ? 4'hF : 4'h0;
      e_lvl = (k >= 3) ? 4'hF : 4'h0;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, 4'h0}) begin
        n_err++;
        $display("FAIL reset_release k=%0d: level=%b press=%b release=%b, expected %b %b 0000",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr);
      end
    end
    // Asynchronous assertion mid-cycle clears outputs without a clock edge.
    #3;
    s_rst = 1'b0;
    #1;
    n_vec++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_async: level=%b press=%b release=%b, expected 0000 0000 0000",
               btn_level, btn_press, btn_release);
    end
    btn_sync = 4'h0;
    tick();
    s_rst = 1'b1;
    tick();
    n_vec++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_idle: level=%b press=%b release=%b, expected 0000 0000 0000",
               btn_level, btn_press, btn_release);
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] e_lvl, e_pr, e_rl;
    btn_sync[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      e_lvl = (k >= 3) ? 4'b0001 : 4'b0000;
      e_pr  = (k == 3) ? 4'b0001 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, 4'h0}) begin
        n_err++;
        $display("FAIL clean_press k=%0d: level=%b press=%b release=%b, expected %b %b 0000",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr);
      end
    end
    btn_sync[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      e_lvl = (k < 3) ? 4'b0001 : 4'b0000;
      e_rl  = (k == 3) ? 4'b0001 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, 4'h0, e_rl}) begin
        n_err++;
        $display("FAIL clean_release k=%0d: level=%b press=%b release=%b, expected %b 0000 %b",
                 k, btn_level, btn_press, btn_release, e_lvl, e_rl);
      end
    end
  endtask

  task automatic test_boundary();
    // 3 high samples (rejected), 2 low, 4 high (accepted), 5 low (release on 4th).
    bit         pin [14] = '{1,1,1,0,0,1,1,1,1,0,0,0,0,0};
    bit         plv [14] = '{0,0,0,0,0,0,0,0,1,1,1,1,0,0};
    logic [3:0] e_lvl, e_pr, e_rl;
    for (int k = 0; k < 14; k++) begin
      btn_sync[2] = pin[k];
      tick();
      e_lvl = plv[k] ? 4'b0100 : 4'b0000;
      e_pr  = (k == 8)  ? 4'b0100 : 4'b0000;
      e_rl  = (k == 12) ? 4'b0100 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, e_rl}) begin
        n_err++;
        $display("FAIL boundary k=%0d: level=%b press=%b release=%b, expected %b %b %b",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr, e_rl);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] e_lvl, e_pr, e_rl;
    btn_sync[3] = 1'b1;
    tick();
    tick();  // ch3 now in WAIT_HI with cnt=2
    n_vec++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      n_err++;
      $display("FAIL midwait_pre: level=%b press=%b release=%b, expected 0000 0000 0000",
               btn_level, btn_press, btn_release);
    end
    #2;
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    // Held input must now need a full 4 fresh samples.
    for (int k = 0; k < 5; k++) begin
      tick();
      e_lvl = (k >= 3) ? 4'b1000 : 4'b0000;
      e_pr  = (k == 3) ? 4'b1000 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, 4'h0}) begin
        n_err++;
        $display("FAIL midwait_press k=%0d: level=%b press=%b release=%b, expected %b %b 0000",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr);
      end
    end
    btn_sync[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      e_lvl = (k < 3) ? 4'b1000 : 4'b0000;
      e_rl  = (k == 3) ? 4'b1000 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, 4'h0, e_rl}) begin
        n_err++;
        $display("FAIL midwait_release k=%0d: level=%b press=%b release=%b, expected %b 0000 %b",
                 k, btn_level, btn_press, btn_release, e_lvl, e_rl);
      end
    end
  endtask

  task automatic test_bounce();
    bit         pin [10] = '{1,0,1,1,0,1,1,1,1,1};
    logic [3:0] e_lvl, e_pr;
    for (int k = 0; k < 10; k++) begin
      btn_sync[1] = pin[k];
      tick();
      e_lvl = (k >= 8) ? 4'b0010 : 4'b0000;
      e_pr  = (k == 8) ? 4'b0010 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, 4'h0}) begin
        n_err++;
        $display("FAIL bounce k=%0d: level=%b press=%b release=%b, expected %b %b 0000",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr);
      end
    end
  endtask

  task automatic test_independence();
    logic [3:0] e_lvl, e_pr, e_rl;
    // ch1 is stable high from the bounce test; ch0 presses as ch1 releases.
    btn_sync[0] = 1'b1;
    btn_sync[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      e_lvl = (k < 3) ? 4'b0010 : 4'b0001;
      e_pr  = (k == 3) ? 4'b0001 : 4'b0000;
      e_rl  = (k == 3) ? 4'b0010 : 4'b0000;
      n_vec++;
      if ({btn_level, btn_press, btn_release} !== {e_lvl, e_pr, e_rl}) begin
        n_err++;
        $display("FAIL independence k=%0d: level=%b press=%b release=%b, expected %b %b %b",
                 k, btn_level, btn_press, btn_release, e_lvl, e_pr, e_rl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_boundary();
    test_reset_mid_wait();
    test_bounce();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
